// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard event inputs and stall/flush controls for pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs_i;
  logic [4:0]       id_rt_i;
  logic             id_uses_rs_i;
  logic             id_uses_rt_i;
  logic             ex_is_load_i;
  logic [4:0]       ex_wd_i;
  logic             id_div_req_i;
  logic             div_done_i;
  logic             exc_req_i;
  logic [4:0]       stall_o;
  logic [4:0]       flush_o;
  logic             div_start_o;
  logic             pc_redirect_o;
  logic             div_timeout_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, ex_is_load_i, ex_wd_i,
    input  id_div_req_i, div_done_i, exc_req_i,
    output stall_o, flush_o, div_start_o, pc_redirect_o, div_timeout_o, state_o, stall_cnt_o
  );

  modport master (
    output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, ex_is_load_i, ex_wd_i,
    output id_div_req_i, div_done_i, exc_req_i,
    input  stall_o, flush_o, div_start_o, pc_redirect_o, div_timeout_o, state_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for load-use, divide and exception events
module pipe_hazard_ctrl #(
  parameter int EXC_FLUSH_CYCLES = 2,
  parameter int DIV_TIMEOUT      = 64,
  parameter int CNT_W            = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DIV_WAIT  = 2'd1,
    ST_EXC_FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] STALL_FRONT = 5'b00011;
  localparam logic [4:0] FLUSH_EX    = 5'b00100;
  localparam logic [4:0] FLUSH_EXC   = 5'b01110;
  localparam logic [4:0] FLUSH_DRAIN = 5'b00110;
  localparam logic [3:0] EXC_LOAD    = 4'(EXC_FLUSH_CYCLES - 1);
  localparam logic [7:0] DIV_LAST    = 8'(DIV_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       exc_cnt_q, exc_cnt_d;
  logic [7:0]       div_cnt_q, div_cnt_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       stall, flush;
  logic             div_start, redirect;
  logic             lu;

  assign lu = hz.ex_is_load_i && (hz.ex_wd_i != 5'd0) &&
              ((hz.id_uses_rs_i && (hz.id_rs_i == hz.ex_wd_i)) ||
               (hz.id_uses_rt_i && (hz.id_rt_i == hz.ex_wd_i)));

  always_comb begin
    state_d   = state_q;
    exc_cnt_d = exc_cnt_q;
    div_cnt_d = div_cnt_q;
    tmo_d     = tmo_q;
    stall     = 5'b00000;
    flush     = 5'b00000;
    div_start = 1'b0;
    redirect  = 1'b0;

    // An exception overrides whatever the current state is doing, including a pending divide.
    if (hz.exc_req_i) begin
      flush     = FLUSH_EXC;
      redirect  = 1'b1;
      state_d   = ST_EXC_FLUSH;
      exc_cnt_d = EXC_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz.id_div_req_i) begin
            div_start = 1'b1;
            stall     = STALL_FRONT;
            flush     = FLUSH_EX;
            state_d   = ST_DIV_WAIT;
            div_cnt_d = 8'd0;
          end else if (lu) begin
            stall = STALL_FRONT;
            flush = FLUSH_EX;
          end
        end
        ST_DIV_WAIT: begin
          if (hz.div_done_i) begin
            state_d = ST_RUN;
          end else if (div_cnt_q == DIV_LAST) begin
            tmo_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            stall     = STALL_FRONT;
            flush     = FLUSH_EX;
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end
        ST_EXC_FLUSH: begin
          flush = FLUSH_DRAIN;
          if (exc_cnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            exc_cnt_d = exc_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    cnt_d = (stall[0] && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      exc_cnt_q <= 4'd0;
      div_cnt_q <= 8'd0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      exc_cnt_q <= exc_cnt_d;
      div_cnt_q <= div_cnt_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hz.stall_o       = stall;
  assign hz.flush_o       = flush;
  assign hz.div_start_o   = div_start;
  assign hz.pc_redirect_o = redirect;
  assign hz.div_timeout_o = tmo_q;
  assign hz.state_o       = state_q;
  assign hz.stall_cnt_o   = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(
    .EXC_FLUSH_CYCLES(2),
    .DIV_TIMEOUT     (8),
    .CNT_W           (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  typedef struct {
    logic [4:0]    stall;
    logic [4:0]    flush;
    logic          start;
    logic          redir;
    logic [1:0]    state;
    logic          tmo;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt;

  function automatic void chk(input string tag, input logic [18:0] got, input logic [18:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%05h want=%05h", tag, got, want);
    end
  endfunction

  task automatic clr_in();
    hz.id_rs_i      = 5'd0;
    hz.id_rt_i      = 5'd0;
    hz.id_uses_rs_i = 1'b0;
    hz.id_uses_rt_i = 1'b0;
    hz.ex_is_load_i = 1'b0;
    hz.ex_wd_i      = 5'd0;
    hz.id_div_req_i = 1'b0;
    hz.div_done_i   = 1'b0;
    hz.exc_req_i    = 1'b0;
  endtask

  // Queue this cycle's expected outputs, advance one clock, then drop all inputs.
  task automatic step(input string tag, input logic [4:0] st, input logic [4:0] fl,
                      input logic sa, input logic rd, input logic [1:0] s, input logic t);
    exp_t e;
    e.stall = st; e.flush = fl; e.start = sa; e.redir = rd;
    e.state = s;  e.tmo = t;    e.cnt = exp_cnt; e.tag = tag;
    sb_q.push_back(e);
    if (st[0] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk); #1;
    clr_in();
  endtask

  task automatic set_lu(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] wd);
    hz.ex_is_load_i = 1'b1;
    hz.id_rs_i = rs; hz.id_uses_rs_i = urs;
    hz.id_rt_i = rt; hz.id_uses_rt_i = urt;
    hz.ex_wd_i = wd;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk(mon_e.tag,
          {hz.stall_o, hz.flush_o, hz.div_start_o, hz.pc_redirect_o, hz.state_o, hz.div_timeout_o, hz.stall_cnt_o},
          {mon_e.stall, mon_e.flush, mon_e.start, mon_e.redir, mon_e.state, mon_e.tmo, mon_e.cnt});
    end
  end

  initial begin
    rst = 1'b1;
    exp_cnt = '0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 19'(hz.state_o), 19'd0);
    chk("rst_outs", {hz.stall_o, hz.flush_o, hz.div_start_o, hz.pc_redirect_o, hz.div_timeout_o, hz.stall_cnt_o}, 19'd0);
    rst = 1'b0;

    step("idle", 5'b0, 5'b0, 0, 0, 2'd0, 0);

    set_lu(5'd5, 1, 5'd0, 0, 5'd5);  step("lu_rs",      5'b00011, 5'b00100, 0, 0, 2'd0, 0);
    step("lu_after", 5'b0, 5'b0, 0, 0, 2'd0, 0);
    set_lu(5'd0, 1, 5'd0, 0, 5'd0);  step("lu_r0",      5'b0, 5'b0, 0, 0, 2'd0, 0);
    set_lu(5'd1, 0, 5'd7, 1, 5'd7);  step("lu_rt",      5'b00011, 5'b00100, 0, 0, 2'd0, 0);
    set_lu(5'd7, 0, 5'd2, 1, 5'd7);  step("lu_rs_unused", 5'b0, 5'b0, 0, 0, 2'd0, 0);
    set_lu(5'd7, 1, 5'd7, 1, 5'd7);
    hz.ex_is_load_i = 1'b0;          step("lu_noload",  5'b0, 5'b0, 0, 0, 2'd0, 0);

    hz.id_div_req_i = 1'b1;          step("div_start",  5'b00011, 5'b00100, 1, 0, 2'd0, 0);
    step("div_w1", 5'b00011, 5'b00100, 0, 0, 2'd1, 0);
    step("div_w2", 5'b00011, 5'b00100, 0, 0, 2'd1, 0);
    step("div_w3", 5'b00011, 5'b00100, 0, 0, 2'd1, 0);
    hz.div_done_i = 1'b1;            step("div_done",   5'b0, 5'b0, 0, 0, 2'd1, 0);
    step("div_back", 5'b0, 5'b0, 0, 0, 2'd0, 0);
    hz.div_done_i = 1'b1;            step("done_in_run", 5'b0, 5'b0, 0, 0, 2'd0, 0);

    set_lu(5'd3, 1, 5'd0, 0, 5'd3);
    hz.id_div_req_i = 1'b1;          step("div_over_lu", 5'b00011, 5'b00100, 1, 0, 2'd0, 0);
    hz.div_done_i = 1'b1;            step("div_fast_done", 5'b0, 5'b0, 0, 0, 2'd1, 0);
    step("div_fast_back", 5'b0, 5'b0, 0, 0, 2'd0, 0);

    hz.id_div_req_i = 1'b1;          step("tmo_start",  5'b00011, 5'b00100, 1, 0, 2'd0, 0);
    for (int i = 0; i < 7; i++)      step("tmo_wait",   5'b00011, 5'b00100, 0, 0, 2'd1, 0);
    step("tmo_last", 5'b0, 5'b0, 0, 0, 2'd1, 0);
    step("tmo_set",  5'b0, 5'b0, 0, 0, 2'd0, 1);
    step("tmo_held", 5'b0, 5'b0, 0, 0, 2'd0, 1);

    hz.id_div_req_i = 1'b1;          step("exc_dstart", 5'b00011, 5'b00100, 1, 0, 2'd0, 1);
    step("exc_dw1", 5'b00011, 5'b00100, 0, 0, 2'd1, 1);
    hz.exc_req_i = 1'b1;             step("exc_in_div", 5'b0, 5'b01110, 0, 1, 2'd1, 1);
    hz.div_done_i = 1'b1;            step("exc_fl1",    5'b0, 5'b00110, 0, 0, 2'd2, 1);
    step("exc_fl2", 5'b0, 5'b00110, 0, 0, 2'd2, 1);
    hz.div_done_i = 1'b1;            step("exc_done_ign", 5'b0, 5'b0, 0, 0, 2'd0, 1);
    set_lu(5'd4, 1, 5'd0, 0, 5'd4);
    hz.exc_req_i = 1'b1;             step("exc_over_lu", 5'b0, 5'b01110, 0, 1, 2'd0, 1);
    hz.exc_req_i = 1'b1;             step("exc_reload", 5'b0, 5'b01110, 0, 1, 2'd2, 1);
    hz.id_div_req_i = 1'b1;          step("exc_rl_fl1", 5'b0, 5'b00110, 0, 0, 2'd2, 1);
    step("exc_rl_fl2", 5'b0, 5'b00110, 0, 0, 2'd2, 1);
    step("exc_rl_run", 5'b0, 5'b0, 0, 0, 2'd0, 1);

    hz.id_div_req_i = 1'b1;          step("rst_dstart", 5'b00011, 5'b00100, 1, 0, 2'd0, 1);
    chk("pre_rst_stall", 19'(hz.stall_o), 19'h3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_state", 19'(hz.state_o), 19'd0);
    chk("async_rst_stall", 19'(hz.stall_o), 19'd0);
    chk("async_rst_cnt",   19'(hz.stall_cnt_o), 19'd0);
    chk("async_rst_tmo",   19'(hz.div_timeout_o), 19'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;

    for (int i = 0; i < 20; i++) begin
      set_lu(5'd0, 0, 5'd9, 1, 5'd9);
      step("sat_lu", 5'b00011, 5'b00100, 0, 0, 2'd0, 0);
    end
    step("sat_end", 5'b0, 5'b0, 0, 0, 2'd0, 0);
    chk("sat_model", 19'(exp_cnt), 19'hF);

    @(negedge clk); #1;
    chk("sb_drained", 19'(sb_q.size()), 19'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
